// File: rtl/canny_pkg.sv
// Shared defaults and helpers for the Canny pipeline stages.
// Counter widths are derived from the frame geometry so every stage agrees on them.
package canny_pkg;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DATA_WIDTH_DEF = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;
    localparam int COL_W_DEF      = cnt_w(IMG_WIDTH_DEF);
    localparam int ROW_W_DEF      = cnt_w(IMG_HEIGHT_DEF);

    // Per-pixel attributes carried alongside the valid shift register.
    typedef struct packed {
        logic win_ok;   // window lies fully inside the frame
        logic last;     // final pixel of the frame
    } tap_flags_t;

endpackage

// File: rtl/matrix_3x3_gen_if.sv
// Pixel-in / 3x3-window-out bundle between the grayscale stage and the Sobel/Gaussian stages.
interface matrix_3x3_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  frame_start;
    logic                  pix_valid;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  matrix_valid;
    logic [DATA_WIDTH-1:0] m11, m12, m13;
    logic [DATA_WIDTH-1:0] m21, m22, m23;
    logic [DATA_WIDTH-1:0] m31, m32, m33;
    logic                  frame_done;

    modport master (
        output frame_start, pix_valid, pix_data,
        input  matrix_valid, m11, m12, m13, m21, m22, m23, m31, m32, m33, frame_done
    );

    modport slave (
        input  frame_start, pix_valid, pix_data,
        output matrix_valid, m11, m12, m13, m21, m22, m23, m31, m32, m33, frame_done
    );
endinterface

// File: rtl/line_buf.sv
// One line of pixel storage: independent write and registered read ports,
// read-before-write when both hit the same address.
module line_buf
    import canny_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = IMG_WIDTH_DEF,
    parameter int ADDR_W     = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // No reset: contents are never cleared, which keeps this mappable to block RAM.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/matrix_3x3_gen.sv
// Raster pixel stream in, registered 3x3 neighbourhood out, two cycles after each accepted pixel.
// Windows touching rows 0..1 or columns 0..1 are shifted through but flagged invalid.
module matrix_3x3_gen
    import canny_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    matrix_3x3_gen_if.slave bus
);

    localparam int COL_W  = cnt_w(IMG_WIDTH);
    localparam int ROW_W  = cnt_w(IMG_HEIGHT);
    localparam int STAGES = 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(2);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_done;

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_done;
    logic             w_acc;
    logic             w_eol;
    logic             w_eof;
    tap_flags_t       w_flags;

    // frame_start acts on the current cycle, so a coincident pixel lands at (0,0).
    assign w_col   = bus.frame_start ? '0   : r_col;
    assign w_row   = bus.frame_start ? '0   : r_row;
    assign w_done  = bus.frame_start ? 1'b0 : r_done;
    assign w_acc   = bus.pix_valid & ~w_done;
    assign w_eol   = (w_col == COL_LAST);
    assign w_eof   = w_eol & (w_row == ROW_LAST);

    assign w_flags.win_ok = (w_row >= ROW_MIN) && (w_col >= COL_MIN);
    assign w_flags.last   = w_eof;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_done <= 1'b0;
        end else if (w_acc) begin
            if (w_eol) begin
                r_col  <= '0;
                r_row  <= w_eof ? '0 : w_row + 1'b1;
                r_done <= w_eof;
            end else begin
                r_col  <= w_col + 1'b1;
                r_row  <= w_row;
                r_done <= 1'b0;
            end
        end else if (bus.frame_start) begin
            r_col  <= '0;
            r_row  <= '0;
            r_done <= 1'b0;
        end
    end

    logic [STAGES:1]       r_vld_pipe;
    tap_flags_t [STAGES:1] r_flags_pipe;
    logic [DATA_WIDTH-1:0] r_pix1;
    logic [COL_W-1:0]      r_col1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe   <= '0;
            r_flags_pipe <= '0;
            r_pix1       <= '0;
            r_col1       <= '0;
        end else begin
            r_vld_pipe   <= {r_vld_pipe[STAGES-1:1], w_acc};
            r_flags_pipe <= {r_flags_pipe[STAGES-1:1], w_flags};
            if (w_acc) begin
                r_pix1 <= bus.pix_data;
                r_col1 <= w_col;
            end
        end
    end

    logic [DATA_WIDTH-1:0] w_lb1_q;
    logic [DATA_WIDTH-1:0] w_lb2_q;

    (* ram_style = "block" *)
    line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (COL_W)
    ) lb1 (
        .clk     (clk),
        .i_we    (w_acc),
        .i_waddr (w_col),
        .i_wdata (bus.pix_data),
        .i_re    (w_acc),
        .i_raddr (w_col),
        .o_rdata (w_lb1_q)
    );

    // The row ageing out of lb1 only exists at its registered output, so its
    // copy into lb2 lands one cycle later at the saved column.
    (* ram_style = "block" *)
    line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_W     (COL_W)
    ) lb2 (
        .clk     (clk),
        .i_we    (r_vld_pipe[1]),
        .i_waddr (r_col1),
        .i_wdata (w_lb1_q),
        .i_re    (w_acc),
        .i_raddr (w_col),
        .o_rdata (w_lb2_q)
    );

    // r_win[row][col]: row 0 is the oldest line, col 2 the newest pixel.
    logic [2:0][2:0][DATA_WIDTH-1:0] r_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (r_vld_pipe[1]) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_lb2_q;
            r_win[1][2] <= w_lb1_q;
            r_win[2][2] <= r_pix1;
        end
    end

    assign bus.matrix_valid = r_vld_pipe[STAGES] & r_flags_pipe[STAGES].win_ok;
    assign bus.frame_done   = r_vld_pipe[STAGES] & r_flags_pipe[STAGES].last;

    assign bus.m11 = r_win[0][0];
    assign bus.m12 = r_win[0][1];
    assign bus.m13 = r_win[0][2];
    assign bus.m21 = r_win[1][0];
    assign bus.m22 = r_win[1][1];
    assign bus.m23 = r_win[1][2];
    assign bus.m31 = r_win[2][0];
    assign bus.m32 = r_win[2][1];
    assign bus.m33 = r_win[2][2];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Scoreboard bench: the driver predicts every valid window from a stored copy of the frame,
// a separate monitor pops and compares whenever the DUT raises matrix_valid.
module tb_matrix_3x3_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_3x3_gen_if #(.DATA_WIDTH(DW)) bus();

    matrix_3x3_gen #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [71:0] win;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [71:0] obs_q[$];
    int          nchk  = 0;
    int          nerr  = 0;
    int          cyc   = 0;
    int          ndone = 0;

    logic [7:0] frame_mem [H][W];
    int         mr = 0;
    int         mc = 0;
    bit         mdone = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [71:0] taps();
        return {bus.m11, bus.m12, bus.m13, bus.m21, bus.m22, bus.m23, bus.m31, bus.m32, bus.m33};
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] want);
        nchk++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: consumes one expectation per valid output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.matrix_valid) begin
                obs_q.push_back(taps());
                if (bus.frame_done) ndone++;
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_valid: got window %0h want none (cycle %0d)", taps(), cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("window", taps(), e.win);
                    check("latency_cycle", 72'(cyc), 72'(e.cyc));
                    check("frame_done", 72'(bus.frame_done), 72'(e.last));
                end
            end else if (bus.frame_done) begin
                nchk++;
                nerr++;
                $display("FAIL lone_frame_done: got 1 want 0 (cycle %0d)", cyc);
            end
        end
    end

    // One input cycle; the model accepts pixels in raster order and predicts t+2 outputs.
    task automatic drive(input bit v, input logic [7:0] d, input bit fs);
        @(posedge clk);
        #1;
        bus.pix_valid   = v;
        bus.pix_data    = d;
        bus.frame_start = fs;
        if (fs) begin
            mr = 0; mc = 0; mdone = 1'b0;
        end
        if (v && !mdone) begin
            frame_mem[mr][mc] = d;
            if (mr >= 2 && mc >= 2) begin
                exp_t e;
                e.win = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.win = (e.win << 8) | 72'(frame_mem[mr-2+i][mc-2+j]);
                e.last = (mr == H-1) && (mc == W-1);
                e.cyc  = cyc + 2;
                exp_q.push_back(e);
            end
            if (mc == W-1) begin
                mc = 0;
                if (mr == H-1) begin
                    mdone = 1'b1;
                    mr = 0;
                end else mr++;
            end else mc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    // mode 0: no frame_start, 1: separate pulse first, 2: pulse with the first pixel.
    task automatic send_frame(input bit pattern, input int gap_pct, input int mode);
        bit first;
        first = 1'b1;
        if (mode == 1) drive(1'b0, 8'h00, 1'b1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(99) < gap_pct) drive(1'b0, 8'($urandom), 1'b0);
                drive(1'b1, pattern ? 8'(r*16 + c) : 8'($urandom), first && (mode == 2));
                first = 1'b0;
            end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_taps"}, taps(), 72'h0);
        check({tag, "_valid"}, 72'(bus.matrix_valid), 72'h0);
        check({tag, "_done"}, 72'(bus.frame_done), 72'h0);
    endtask

    // Pattern frame: six windows, known first/last contents, one frame_done.
    task automatic check_pattern_frame(input string tag, input int base_obs, input int base_done);
        check({tag, "_count"}, 72'(obs_q.size() - base_obs), 72'd6);
        check({tag, "_ndone"}, 72'(ndone - base_done), 72'd1);
        if (obs_q.size() - base_obs == 6) begin
            check({tag, "_first"}, obs_q[base_obs],     72'h00_01_02_10_11_12_20_21_22);
            check({tag, "_last"},  obs_q[base_obs + 5], 72'h12_13_14_22_23_24_32_33_34);
        end
        check({tag, "_drained"}, 72'(exp_q.size()), 72'd0);
    endtask

    initial begin
        int bo, bd;
        bus.pix_valid   = 1'b0;
        bus.pix_data    = '0;
        bus.frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;

        bo = obs_q.size(); bd = ndone;
        send_frame(1'b1, 0, 0);
        idle(4);
        check_pattern_frame("basic", bo, bd);

        bo = obs_q.size(); bd = ndone;
        send_frame(1'b1, 40, 1);
        idle(4);
        check_pattern_frame("gaps", bo, bd);

        // Random data over stale RAM: the scoreboard rejects any border window.
        bo = obs_q.size(); bd = ndone;
        send_frame(1'b0, 30, 1);
        idle(4);
        check("random_count", 72'(obs_q.size() - bo), 72'd6);

        // Overrun: extra pixels after the last one are ignored.
        bo = obs_q.size(); bd = ndone;
        for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom), 1'b0);
        idle(4);
        check("overrun_valid", 72'(obs_q.size() - bo), 72'd0);
        check("overrun_done", 72'(ndone - bd), 72'd0);

        bo = obs_q.size(); bd = ndone;
        send_frame(1'b1, 0, 2);
        idle(4);
        check_pattern_frame("coincident", bo, bd);

        // Reset just as pixel (2,3) would be presented.
        drive(1'b0, 8'h00, 1'b1);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                if (r < 2 || c < 3) drive(1'b1, 8'(r*16 + c), 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.pix_valid = 1'b0;
        exp_q.delete();
        mr = 0; mc = 0; mdone = 1'b0;
        #1;
        check_zero("reset_midframe");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bo = obs_q.size(); bd = ndone;
        send_frame(1'b1, 0, 0);
        idle(4);
        check_pattern_frame("after_reset", bo, bd);

        for (int f = 0; f < 4; f++) begin
            bo = obs_q.size();
            send_frame(1'b0, 35, 1 + (f % 2));
            idle(4);
            check("rand_frame_count", 72'(obs_q.size() - bo), 72'd6);
        end
        check("final_drained", 72'(exp_q.size()), 72'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
